alu_scheduler: RTL and testbench



---
 rtl/alu_sched_pkg.sv | 16 +
 rtl/alu_scheduler_arb.sv | 37 +++
 rtl/alu_scheduler.sv | 134 +++++++++++++
 tb/tb_alu_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StMul, StResp} state_t;

    localparam logic [2:0] FuncAddOne     = 3'b000;
    localparam logic [2:0] FuncAddRca     = 3'b001;
    localparam logic [2:0] FuncAddBuiltin = 3'b010;
    localparam logic [2:0] FuncOrXor      = 3'b011;
    localparam logic [2:0] FuncReduceOr   = 3'b100;
    localparam logic [2:0] FuncConcat     = 3'b101;
    localparam logic [2:0] FuncMul        = 3'b110;

    localparam int unsigned MulIters = 4;

endpackage

// File: rtl/alu_scheduler_arb.sv
// Two-requester round-robin arbiter; pointer holds the last granted requester.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr_q;
    logic gid;

    // Pick the requester; on a tie the one that was not granted last wins.
    always_comb begin
        gid   = 1'b0;
        grant = 2'b00;
        case (req)
            2'b01:   gid = 1'b0;
            2'b10:   gid = 1'b1;
            2'b11:   gid = ~ptr_q;
            default: gid = 1'b0;
        endcase
        if (en && (req != 2'b00)) begin
            grant[gid] = 1'b1;
        end
    end

    // Remember who was granted; reset value lets requester 0 win the first tie.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b1;
        end else if (grant != 2'b00) begin
            ptr_q <= grant[1];
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Sequencer for the external 4-bit ALU: arbitrates two requesters, drives the
// ALU, and returns a tagged 8-bit result. Define ALU_SCHED_MUL_EN to build the
// four-cycle shift-and-add multiply for func 110.
module alu_scheduler (
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [2:0] func0,
    input  logic [2:0] func1,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] b0,
    input  logic [3:0] b1,
    output logic [1:0] ack,
    output logic [2:0] alu_func,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       result_id,
    output logic       busy
);
    import alu_sched_pkg::*;

    state_t     state;
    logic       id_q;
    logic [1:0] grant;
    logic [2:0] sel_func;
    logic [3:0] sel_a;
    logic [3:0] sel_b;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .resetn (resetn),
        .en     (state == StIdle),
        .req    (req),
        .grant  (grant)
    );

    // Operands of whichever requester is being granted.
    always_comb begin
        sel_func = grant[1] ? func1 : func0;
        sel_a    = grant[1] ? a1 : a0;
        sel_b    = grant[1] ? b1 : b0;
    end

`ifdef ALU_SCHED_MUL_EN
    logic [7:0] acc_q;
    logic [7:0] acc_next;
    logic [1:0] iter_q;

    // One shift-and-add step: add A into the high nibble when the low bit is set.
    always_comb begin
        acc_next = acc_q[0] ? {alu_result[4:0], acc_q[3:1]} : {1'b0, acc_q[7:1]};
    end
`endif

    // Main FSM; alu_* act as the operand latch and hold in IDLE/RESP.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= StIdle;
            id_q         <= 1'b0;
            ack          <= 2'b00;
            alu_func     <= 3'b000;
            alu_a        <= 4'h0;
            alu_b        <= 4'h0;
            result       <= 8'h00;
            result_valid <= 1'b0;
            result_id    <= 1'b0;
            busy         <= 1'b0;
`ifdef ALU_SCHED_MUL_EN
            acc_q        <= 8'h00;
            iter_q       <= 2'd0;
`endif
        end else begin
            ack          <= 2'b00;
            result_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant != 2'b00) begin
                        ack  <= grant;
                        id_q <= grant[1];
                        busy <= 1'b1;
`ifdef ALU_SCHED_MUL_EN
                        iter_q <= 2'd0;
                        if (sel_func == FuncMul) begin
                            state    <= StMul;
                            alu_func <= FuncAddRca;
                            alu_a    <= 4'h0;
                            alu_b    <= sel_a;
                            acc_q    <= {4'h0, sel_b};
                        end else
`endif
                        begin
                            state    <= StIssue;
                            alu_func <= sel_func;
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                        end
                    end
                end
                StIssue: begin
                    result       <= alu_result;
                    result_valid <= 1'b1;
                    result_id    <= id_q;
                    state        <= StResp;
                end
`ifdef ALU_SCHED_MUL_EN
                StMul: begin
                    acc_q  <= acc_next;
                    alu_a  <= acc_next[7:4];
                    iter_q <= iter_q + 2'd1;
                    if (iter_q == 2'(MulIters - 1)) begin
                        result       <= acc_next;
                        result_valid <= 1'b1;
                        result_id    <= id_q;
                        state        <= StResp;
                    end
                end
`endif
                StResp: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: transaction-level reference model plus directed vectors.
module tb_alu_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic [1:0] req = 2'b00;
    logic [2:0] func0 = 3'd0, func1 = 3'd0;
    logic [3:0] a0 = 4'd0, a1 = 4'd0, b0 = 4'd0, b1 = 4'd0;
    logic [1:0] ack;
    logic [2:0] alu_func;
    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_result;
    logic [7:0] result;
    logic       result_valid;
    logic       result_id;
    logic       busy;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    alu_scheduler dut (
        .clock        (clock),
        .resetn       (resetn),
        .req          (req),
        .func0        (func0),
        .func1        (func1),
        .a0           (a0),
        .a1           (a1),
        .b0           (b0),
        .b1           (b1),
        .ack          (ack),
        .alu_func     (alu_func),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Behaviour of the external ALU.
    function automatic logic [7:0] alu_fn(input logic [2:0] f, input logic [3:0] x,
                                          input logic [3:0] y);
        case (f)
            3'b000:  alu_fn = {4'h0, x} + 8'd1;
            3'b001:  alu_fn = {4'h0, x} + {4'h0, y};
            3'b010:  alu_fn = {4'h0, x} + {4'h0, y};
            3'b011:  alu_fn = {x | y, x ^ y};
            3'b100:  alu_fn = {7'd0, |{x, y}};
            3'b101:  alu_fn = {x, y};
            default: alu_fn = 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_func, alu_a, alu_b);

    function automatic logic is_mul(input logic [2:0] f);
`ifdef ALU_SCHED_MUL_EN
        is_mul = (f == 3'b110);
`else
        is_mul = 1'b0;
`endif
    endfunction

    function automatic logic [7:0] op_result(input logic [2:0] f, input logic [3:0] x,
                                             input logic [3:0] y);
        if (is_mul(f)) op_result = 8'({4'h0, x} * {4'h0, y});
        else op_result = alu_fn(f, x, y);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an operation occupies a fixed number of cycles after
    // its grant and reports its result in the last busy cycle.
    int         m_left;
    logic       m_ptr;
    logic       m_id;
    logic [7:0] m_res;
    logic [1:0] exp_ack;
    logic       exp_valid, exp_busy, exp_id;
    logic [7:0] exp_result;

    always @(posedge clock or negedge resetn) begin
        logic       g;
        logic [2:0] f;
        logic [3:0] x, y;
        if (!resetn) begin
            m_left = 0; m_ptr = 1'b1; m_id = 1'b0; m_res = 8'h00;
            exp_ack = 2'b00; exp_valid = 1'b0; exp_busy = 1'b0;
            exp_id = 1'b0; exp_result = 8'h00;
        end else begin
            exp_ack = 2'b00;
            exp_valid = 1'b0;
            if (m_left == 0) begin
                if (req != 2'b00) begin
                    g = (req == 2'b11) ? ~m_ptr : req[1];
                    m_ptr = g;
                    m_id = g;
                    exp_ack = g ? 2'b10 : 2'b01;
                    f = g ? func1 : func0;
                    x = g ? a1 : a0;
                    y = g ? b1 : b0;
                    m_res = op_result(f, x, y);
                    m_left = is_mul(f) ? 5 : 2;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    exp_valid = 1'b1;
                    exp_result = m_res;
                    exp_id = m_id;
                end
            end
            exp_busy = (m_left != 0);
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("ack", 32'(ack), 32'(exp_ack));
            check("result_valid", 32'(result_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(exp_busy));
            check("result", 32'(result), 32'(exp_result));
            check("result_id", 32'(result_id), 32'(exp_id));
        end
    end

    // Per-requester operation queues {func, a, b} and result log.
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [7:0]  log_res[8];
    logic        log_id[8];
    int          busy_cnt;

    task automatic raise(input int i);
        logic [10:0] op;
        if (i == 0) begin
            op = q0.pop_front();
            {func0, a0, b0} = op;
        end else begin
            op = q1.pop_front();
            {func1, a1, b1} = op;
        end
        req[i] = 1'b1;
    endtask

    // Serve both queues until n results are logged, then let the DUT settle.
    task automatic run(input int n, input string name);
        int seen = 0;
        int cyc = 0;
        busy_cnt = 0;
        while (seen < n && cyc < 60) begin
            if (!req[0] && q0.size() > 0) raise(0);
            if (!req[1] && q1.size() > 0) raise(1);
            @(posedge clock); #1;
            cyc++;
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
            if (busy) busy_cnt++;
            if (result_valid) begin
                log_res[seen] = result;
                log_id[seen] = result_id;
                seen++;
            end
        end
        check({name, "_count"}, 32'(seen), 32'(n));
        repeat (2) begin
            @(posedge clock); #1;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"}, 32'(ack), 32'd0);
        check({name, "_alu_func"}, 32'(alu_func), 32'd0);
        check({name, "_alu_a"}, 32'(alu_a), 32'd0);
        check({name, "_alu_b"}, 32'(alu_b), 32'd0);
        check({name, "_result"}, 32'(result), 32'd0);
        check({name, "_valid"}, 32'(result_valid), 32'd0);
        check({name, "_id"}, 32'(result_id), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int vcnt;
        #3 resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        chk_en = 1'b1;
        resetn = 1'b1;

        // Tie after reset goes to 0; requester 0 keeps asking, so 1 wins the next tie.
        q0.push_back({3'b011, 4'hA, 4'h6});
        q0.push_back({3'b101, 4'h7, 4'h8});
        q1.push_back({3'b101, 4'h3, 4'h5});
        run(3, "tie");
        check("tie_r0", 32'(log_res[0]), 32'h EC);
        check("tie_id0", 32'(log_id[0]), 32'd0);
        check("tie_r1", 32'(log_res[1]), 32'h35);
        check("tie_id1", 32'(log_id[1]), 32'd1);
        check("tie_r2", 32'(log_res[2]), 32'h78);
        check("tie_id2", 32'(log_id[2]), 32'd0);

        // Single requester, ripple-carry add.
        q0.push_back({3'b001, 4'h9, 4'h8});
        run(1, "add");
        check("add_r", 32'(log_res[0]), 32'h11);
        check("add_id", 32'(log_id[0]), 32'd0);
        check("add_busy", 32'(busy_cnt), 32'd2);

        // Reduce-OR boundaries, and the held result afterwards.
        q1.push_back({3'b100, 4'h0, 4'h0});
        q1.push_back({3'b100, 4'h0, 4'h1});
        run(2, "ror");
        check("ror_r0", 32'(log_res[0]), 32'h00);
        check("ror_r1", 32'(log_res[1]), 32'h01);
        check("ror_hold", 32'(result), 32'h01);

        // Func 111 always returns zero.
        q0.push_back({3'b111, 4'hF, 4'hF});
        run(1, "f7");
        check("f7_r", 32'(log_res[0]), 32'h00);

`ifdef ALU_SCHED_MUL_EN
        q1.push_back({3'b110, 4'hF, 4'hF});
        run(1, "mul");
        check("mul_r", 32'(log_res[0]), 32'h E1);
        check("mul_id", 32'(log_id[0]), 32'd1);
        check("mul_busy", 32'(busy_cnt), 32'd5);
        q1.push_back({3'b110, 4'h0, 4'h7});
        run(1, "mul0");
        check("mul0_r", 32'(log_res[0]), 32'h00);
`else
        q0.push_back({3'b110, 4'h3, 4'h4});
        run(1, "nomul");
        check("nomul_r", 32'(log_res[0]), 32'h00);
        check("nomul_busy", 32'(busy_cnt), 32'd2);
`endif

        // Reset in the middle of an operation.
        func0 = 3'b110; a0 = 4'h5; b0 = 4'h6;
        req[0] = 1'b1;
        cyc = 0;
        while (!ack[0] && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("rst_ack_seen", 32'(ack[0]), 32'd1);
        req[0] = 1'b0;
`ifdef ALU_SCHED_MUL_EN
        repeat (2) begin
            @(posedge clock); #1;
        end
`endif
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clock); #1;
        resetn = 1'b1;
        vcnt = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (result_valid) vcnt++;
        end
        check("midrst_novalid", 32'(vcnt), 32'd0);

        q1.push_back({3'b010, 4'h4, 4'h5});
        q0.push_back({3'b000, 4'h5, 4'h0});
        run(2, "tie2");
        check("tie2_id0", 32'(log_id[0]), 32'd0);
        check("tie2_r0", 32'(log_res[0]), 32'h06);
        check("tie2_r1", 32'(log_res[1]), 32'h09);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
